// File: rtl/uart_bus_sched.sv
// Bus scheduler for the CoreUART host port: round-robin TX arbitration with packet lock,
// RX drain into a valid/ready holding register, strobe generation and safe-point config updates.
module uart_bus_sched #(
  parameter int          NREQ     = 4,
  parameter int          HOLDOFF  = 2,
  parameter logic [12:0] BAUD_RST = 13'd26
) (
  input  logic                CLK,
  input  logic                RESET_N,
  input  logic [NREQ*8-1:0]   TX_DATA,
  input  logic [NREQ-1:0]     TX_VALID,
  input  logic [NREQ-1:0]     TX_LAST,
  output logic [NREQ-1:0]     TX_READY,
  output logic [2:0]          TX_GRANT,
  output logic [7:0]          RX_DATA,
  output logic                RX_PERR,
  output logic                RX_FERR,
  output logic                RX_OVF,
  output logic                RX_VALID,
  input  logic                RX_READY,
  input  logic [12:0]         CFG_BAUD,
  input  logic                CFG_BIT8,
  input  logic                CFG_PAR_EN,
  input  logic                CFG_ODD,
  input  logic                CFG_LOAD,
  output logic                CFG_BUSY,
  output logic [15:0]         ERR_PAR_CNT,
  output logic [15:0]         ERR_FRM_CNT,
  output logic [15:0]         ERR_OVF_CNT,
  output logic                UART_CSN,
  output logic                UART_WEN,
  output logic                UART_OEN,
  output logic [7:0]          UART_DIN,
  output logic [12:0]         UART_BAUD,
  output logic                UART_BIT8,
  output logic                UART_PAR_EN,
  output logic                UART_ODD,
  input  logic [7:0]          UART_DOUT,
  input  logic                UART_TXRDY,
  input  logic                UART_RXRDY,
  input  logic                UART_PERR,
  input  logic                UART_FERR,
  input  logic                UART_OVF
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WR   = 2'd1;
  localparam logic [1:0] ST_RD   = 2'd2;
  localparam logic [1:0] ST_HOLD = 2'd3;

  logic [1:0]  state_reg, state_next;
  logic [2:0]  hold_cnt_reg;
  logic [2:0]  grant_reg;
  logic        lock_reg;
  logic        csn_reg, wen_reg, oen_reg;
  logic [7:0]  din_reg;
  logic [7:0]  rx_data_reg;
  logic        rx_perr_reg, rx_ferr_reg, rx_ovf_reg, rx_valid_reg;
  logic [15:0] err_par_cnt_reg, err_frm_cnt_reg, err_ovf_cnt_reg;
  logic [12:0] shadow_baud_reg, baud_reg;
  logic        shadow_bit8_reg, shadow_par_reg, shadow_odd_reg;
  logic        bit8_reg, par_reg, odd_reg;
  logic        cfg_busy_reg;

  // Requester vectors padded to 8 so the 3-bit grant can index them directly.
  logic [7:0] tx_valid_ext, tx_last_ext;
  logic [7:0] tx_byte [8];

  assign tx_valid_ext = 8'(TX_VALID);
  assign tx_last_ext  = 8'(TX_LAST);

  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_byte
      if (gi < NREQ) begin : g_used
        assign tx_byte[gi] = TX_DATA[8*gi +: 8];
      end else begin : g_pad
        assign tx_byte[gi] = 8'd0;
      end
    end
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_ready
      assign TX_READY[gi] = (state_reg == ST_WR) && (grant_reg == 3'(gi));
    end
  endgenerate

  // Round robin: scan from farthest to nearest so the nearest valid requester after the grant wins.
  logic [2:0] rr_pick;
  logic       rr_found;
  always_comb begin : p_rr
    int idx;
    idx      = 0;
    rr_found = 1'b0;
    rr_pick  = grant_reg;
    for (int off = NREQ; off >= 1; off--) begin
      idx = int'(grant_reg) + off;
      if (idx >= NREQ) idx = idx - NREQ;
      if (tx_valid_ext[idx[2:0]]) begin
        rr_found = 1'b1;
        rr_pick  = idx[2:0];
      end
    end
  end

  logic [2:0] cand_id;
  logic       cand_ok, cfg_apply, start_rd, start_wr;
  always_comb begin
    cand_id   = lock_reg ? grant_reg : rr_pick;
    cand_ok   = lock_reg ? tx_valid_ext[grant_reg] : rr_found;
    cfg_apply = (state_reg == ST_IDLE) && cfg_busy_reg && !lock_reg;
    start_rd  = (state_reg == ST_IDLE) && !cfg_apply && UART_RXRDY && !rx_valid_reg;
    start_wr  = (state_reg == ST_IDLE) && !cfg_apply && !start_rd && UART_TXRDY && cand_ok;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: begin
        if (start_rd)      state_next = ST_RD;
        else if (start_wr) state_next = ST_WR;
      end
      ST_WR, ST_RD: state_next = ST_HOLD;
      ST_HOLD: if (hold_cnt_reg == 3'd0) state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_reg    <= ST_IDLE;
      hold_cnt_reg <= 3'd0;
      grant_reg    <= 3'(NREQ - 1);
      lock_reg     <= 1'b0;
      csn_reg      <= 1'b1;
      wen_reg      <= 1'b1;
      oen_reg      <= 1'b1;
      din_reg      <= 8'd0;
    end else begin
      state_reg <= state_next;
      // Strobes are registered, so they are low exactly during the WR/RD cycle.
      csn_reg   <= !(start_wr || start_rd);
      wen_reg   <= !start_wr;
      oen_reg   <= !start_rd;
      if (start_wr) begin
        grant_reg <= cand_id;
        din_reg   <= tx_byte[cand_id];
      end
      if (state_reg == ST_WR) lock_reg <= !tx_last_ext[grant_reg];
      if (state_reg == ST_WR || state_reg == ST_RD)
        hold_cnt_reg <= 3'(HOLDOFF - 1);
      else if (state_reg == ST_HOLD && hold_cnt_reg != 3'd0)
        hold_cnt_reg <= hold_cnt_reg - 3'd1;
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      rx_data_reg     <= 8'd0;
      rx_perr_reg     <= 1'b0;
      rx_ferr_reg     <= 1'b0;
      rx_ovf_reg      <= 1'b0;
      rx_valid_reg    <= 1'b0;
      err_par_cnt_reg <= 16'd0;
      err_frm_cnt_reg <= 16'd0;
      err_ovf_cnt_reg <= 16'd0;
    end else begin
      if (state_reg == ST_RD) begin
        rx_data_reg  <= UART_DOUT;
        rx_perr_reg  <= UART_PERR;
        rx_ferr_reg  <= UART_FERR;
        rx_ovf_reg   <= UART_OVF;
        rx_valid_reg <= 1'b1;
      end else if (rx_valid_reg && RX_READY) begin
        rx_valid_reg <= 1'b0;
      end
      if (state_reg == ST_RD && UART_PERR && err_par_cnt_reg != 16'hFFFF)
        err_par_cnt_reg <= err_par_cnt_reg + 16'd1;
      if (state_reg == ST_RD && UART_FERR && err_frm_cnt_reg != 16'hFFFF)
        err_frm_cnt_reg <= err_frm_cnt_reg + 16'd1;
      if (state_reg == ST_RD && UART_OVF && err_ovf_cnt_reg != 16'hFFFF)
        err_ovf_cnt_reg <= err_ovf_cnt_reg + 16'd1;
    end
  end

  // A load arriving in the apply cycle wins: busy stays set and the newer shadow is applied later.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      shadow_baud_reg <= BAUD_RST;
      shadow_bit8_reg <= 1'b1;
      shadow_par_reg  <= 1'b0;
      shadow_odd_reg  <= 1'b0;
      cfg_busy_reg    <= 1'b0;
      baud_reg        <= BAUD_RST;
      bit8_reg        <= 1'b1;
      par_reg         <= 1'b0;
      odd_reg         <= 1'b0;
    end else begin
      if (CFG_LOAD) begin
        shadow_baud_reg <= CFG_BAUD;
        shadow_bit8_reg <= CFG_BIT8;
        shadow_par_reg  <= CFG_PAR_EN;
        shadow_odd_reg  <= CFG_ODD;
        cfg_busy_reg    <= 1'b1;
      end else if (cfg_apply) begin
        cfg_busy_reg    <= 1'b0;
      end
      if (cfg_apply) begin
        baud_reg <= shadow_baud_reg;
        bit8_reg <= shadow_bit8_reg;
        par_reg  <= shadow_par_reg;
        odd_reg  <= shadow_odd_reg;
      end
    end
  end

  assign TX_GRANT    = grant_reg;
  assign RX_DATA     = rx_data_reg;
  assign RX_PERR     = rx_perr_reg;
  assign RX_FERR     = rx_ferr_reg;
  assign RX_OVF      = rx_ovf_reg;
  assign RX_VALID    = rx_valid_reg;
  assign CFG_BUSY    = cfg_busy_reg;
  assign ERR_PAR_CNT = err_par_cnt_reg;
  assign ERR_FRM_CNT = err_frm_cnt_reg;
  assign ERR_OVF_CNT = err_ovf_cnt_reg;
  assign UART_CSN    = csn_reg;
  assign UART_WEN    = wen_reg;
  assign UART_OEN    = oen_reg;
  assign UART_DIN    = din_reg;
  assign UART_BAUD   = baud_reg;
  assign UART_BIT8   = bit8_reg;
  assign UART_PAR_EN = par_reg;
  assign UART_ODD    = odd_reg;

endmodule

// File: tb/tb_uart_bus_sched.sv
// Scoreboard bench for uart_bus_sched: requester and UART models driven on the falling edge,
// expected UART writes and RX bytes queued by the scenario and popped as the DUT produces them.
module tb_uart_bus_sched;

  localparam int          NREQ     = 4;
  localparam int          HOLDOFF  = 2;
  localparam logic [12:0] BAUD_RST = 13'd26;

  logic        CLK = 1'b0;
  logic        RESET_N;
  logic [31:0] TX_DATA;
  logic [3:0]  TX_VALID, TX_LAST, TX_READY;
  logic [2:0]  TX_GRANT;
  logic [7:0]  RX_DATA;
  logic        RX_PERR, RX_FERR, RX_OVF, RX_VALID, RX_READY;
  logic [12:0] CFG_BAUD;
  logic        CFG_BIT8, CFG_PAR_EN, CFG_ODD, CFG_LOAD, CFG_BUSY;
  logic [15:0] ERR_PAR_CNT, ERR_FRM_CNT, ERR_OVF_CNT;
  logic        UART_CSN, UART_WEN, UART_OEN;
  logic [7:0]  UART_DIN;
  logic [12:0] UART_BAUD;
  logic        UART_BIT8, UART_PAR_EN, UART_ODD;
  logic [7:0]  UART_DOUT;
  logic        UART_TXRDY, UART_RXRDY, UART_PERR, UART_FERR, UART_OVF;

  always #5 CLK = ~CLK;

  uart_bus_sched #(.NREQ(NREQ), .HOLDOFF(HOLDOFF), .BAUD_RST(BAUD_RST)) dut (
    .CLK(CLK), .RESET_N(RESET_N),
    .TX_DATA(TX_DATA), .TX_VALID(TX_VALID), .TX_LAST(TX_LAST), .TX_READY(TX_READY), .TX_GRANT(TX_GRANT),
    .RX_DATA(RX_DATA), .RX_PERR(RX_PERR), .RX_FERR(RX_FERR), .RX_OVF(RX_OVF),
    .RX_VALID(RX_VALID), .RX_READY(RX_READY),
    .CFG_BAUD(CFG_BAUD), .CFG_BIT8(CFG_BIT8), .CFG_PAR_EN(CFG_PAR_EN), .CFG_ODD(CFG_ODD),
    .CFG_LOAD(CFG_LOAD), .CFG_BUSY(CFG_BUSY),
    .ERR_PAR_CNT(ERR_PAR_CNT), .ERR_FRM_CNT(ERR_FRM_CNT), .ERR_OVF_CNT(ERR_OVF_CNT),
    .UART_CSN(UART_CSN), .UART_WEN(UART_WEN), .UART_OEN(UART_OEN), .UART_DIN(UART_DIN),
    .UART_BAUD(UART_BAUD), .UART_BIT8(UART_BIT8), .UART_PAR_EN(UART_PAR_EN), .UART_ODD(UART_ODD),
    .UART_DOUT(UART_DOUT), .UART_TXRDY(UART_TXRDY), .UART_RXRDY(UART_RXRDY),
    .UART_PERR(UART_PERR), .UART_FERR(UART_FERR), .UART_OVF(UART_OVF)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboards: writes as {id[2:0], data}, RX bytes as {data, perr, ferr, ovf}.
  logic [10:0] exp_wr[$];
  logic [10:0] exp_rx[$];

  logic [8:0]  rq_buf [4][16];
  int          rq_head [4];
  int          rq_tail [4];
  logic [3:0]  acc_prev;

  logic        rx_go, rx_ready_want;
  logic [7:0]  rx_d;
  logic        rx_p, rx_f, rx_o;
  logic [12:0] exp_baud;
  logic [15:0] m_par, m_frm, m_ovf;

  int cycle = 0, wr_cnt = 0, oen_cnt = 0;
  int last_strobe = -100, wr_cycle = 0, rd_cycle = 0;
  logic rd_pend = 1'b0;
  logic [12:0] prev_baud = BAUD_RST;

  // Falling-edge engine: monitors, RX consumer, UART model and requester drivers.
  initial begin : engine
    logic [10:0] e;
    forever begin
      @(negedge CLK);
      cycle++;
      for (int i = 0; i < 4; i++)
        if (acc_prev[i] && rq_head[i] < rq_tail[i]) rq_head[i]++;
      acc_prev = TX_READY;

      if (rd_pend) begin
        chk("rx_valid_latency", RX_VALID, 1);
        rd_pend = 1'b0;
      end
      if (!UART_CSN && !UART_WEN) begin
        wr_cnt++;
        wr_cycle = cycle;
        chk("wr_expected", exp_wr.size() != 0, 1);
        if (exp_wr.size() != 0) begin
          e = exp_wr.pop_front();
          chk("wr_grant", TX_GRANT, e[10:8]);
          chk("wr_data", UART_DIN, e[7:0]);
          chk("wr_tx_ready", TX_READY, 4'b1 << e[9:8]);
        end
        chk("wr_spacing", (cycle - last_strobe) >= HOLDOFF + 1, 1);
        last_strobe = cycle;
        $display("wr   cyc=%0d id=%0d data=%02h", cycle, TX_GRANT, UART_DIN);
      end else if (TX_READY != 4'd0) begin
        chk("tx_ready_idle", TX_READY, 0);
      end
      if (!UART_CSN && !UART_OEN) begin
        oen_cnt++;
        rd_cycle = cycle;
        chk("rd_spacing", (cycle - last_strobe) >= HOLDOFF + 1, 1);
        last_strobe = cycle;
        rd_pend = 1'b1;
        UART_RXRDY = 1'b0;
      end
      if (UART_BAUD !== prev_baud) begin
        chk("cfg_quiet", {UART_CSN, UART_WEN, UART_OEN}, 3'b111);
        chk("cfg_baud", UART_BAUD, exp_baud);
        chk("cfg_busy_clr", CFG_BUSY, 0);
        prev_baud = UART_BAUD;
      end

      RX_READY = rx_ready_want;
      if (RX_VALID && RX_READY) begin
        chk("rx_expected", exp_rx.size() != 0, 1);
        if (exp_rx.size() != 0) begin
          e = exp_rx.pop_front();
          chk("rx_data", RX_DATA, e[10:3]);
          chk("rx_flags", {RX_PERR, RX_FERR, RX_OVF}, e[2:0]);
        end
        $display("rx   cyc=%0d data=%02h flags=%b", cycle, RX_DATA, {RX_PERR, RX_FERR, RX_OVF});
      end
      if (rx_go) begin
        UART_DOUT = rx_d; UART_PERR = rx_p; UART_FERR = rx_f; UART_OVF = rx_o;
        UART_RXRDY = 1'b1;
        rx_go = 1'b0;
      end

      for (int i = 0; i < 4; i++) begin
        TX_VALID[i]       = rq_head[i] < rq_tail[i];
        TX_DATA[8*i +: 8] = rq_buf[i][rq_head[i] % 16][7:0];
        TX_LAST[i]        = rq_buf[i][rq_head[i] % 16][8];
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic send(input int id, input logic [7:0] d, input logic last);
    rq_buf[id][rq_tail[id] % 16] = {last, d};
    rq_tail[id]++;
  endtask

  task automatic uart_rx(input logic [7:0] d, input logic p, input logic f, input logic o);
    int n = 0;
    while ((UART_RXRDY || rx_go) && n < 200) begin cyc(1); n++; end
    chk("uart_rx_free", UART_RXRDY, 0);
    rx_d = d; rx_p = p; rx_f = f; rx_o = o;
    rx_go = 1'b1;
    exp_rx.push_back({d, p, f, o});
    if (p && m_par != 16'hFFFF) m_par++;
    if (f && m_frm != 16'hFFFF) m_frm++;
    if (o && m_ovf != 16'hFFFF) m_ovf++;
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_wr.size() != 0 || exp_rx.size() != 0 || rx_go) && n < 400) begin cyc(1); n++; end
    chk("drain", exp_wr.size() + exp_rx.size(), 0);
    cyc(HOLDOFF + 4);
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_strobes"}, {UART_CSN, UART_WEN, UART_OEN}, 3'b111);
    chk({tag, "_din"}, UART_DIN, 0);
    chk({tag, "_baud"}, UART_BAUD, BAUD_RST);
    chk({tag, "_cfgbits"}, {UART_BIT8, UART_PAR_EN, UART_ODD}, 3'b100);
    chk({tag, "_tx_ready"}, TX_READY, 0);
    chk({tag, "_grant"}, TX_GRANT, NREQ - 1);
    chk({tag, "_rx_valid"}, RX_VALID, 0);
    chk({tag, "_rx_hold"}, {RX_DATA, RX_PERR, RX_FERR, RX_OVF}, 0);
    chk({tag, "_counters"}, {ERR_PAR_CNT, ERR_FRM_CNT, ERR_OVF_CNT}, 0);
    chk({tag, "_cfg_busy"}, CFG_BUSY, 0);
  endtask

  initial begin : scenario
    int w0, r0, n;
    RESET_N = 1'b0;
    TX_DATA = '0; TX_VALID = '0; TX_LAST = '0; RX_READY = 1'b0;
    CFG_BAUD = '0; CFG_BIT8 = 1'b0; CFG_PAR_EN = 1'b0; CFG_ODD = 1'b0; CFG_LOAD = 1'b0;
    UART_DOUT = '0; UART_TXRDY = 1'b1; UART_RXRDY = 1'b0;
    UART_PERR = 1'b0; UART_FERR = 1'b0; UART_OVF = 1'b0;
    rx_go = 1'b0; rx_ready_want = 1'b1; acc_prev = '0;
    rx_d = '0; rx_p = 1'b0; rx_f = 1'b0; rx_o = 1'b0;
    exp_baud = BAUD_RST; m_par = '0; m_frm = '0; m_ovf = '0;
    for (int i = 0; i < 4; i++) begin
      rq_head[i] = 0; rq_tail[i] = 0;
      for (int j = 0; j < 16; j++) rq_buf[i][j] = '0;
    end
    cyc(3);
    check_reset("rst");
    RESET_N = 1'b1;
    cyc(2);

    // Round robin from the reset pointer: 0, 2, 3.
    send(0, 8'h10, 1); send(2, 8'h12, 1); send(3, 8'h13, 1);
    exp_wr.push_back({3'd0, 8'h10}); exp_wr.push_back({3'd2, 8'h12}); exp_wr.push_back({3'd3, 8'h13});
    drain();

    // Single byte from requester 1.
    w0 = wr_cnt;
    send(1, 8'hA5, 1);
    exp_wr.push_back({3'd1, 8'hA5});
    drain();
    chk("single_wr_count", wr_cnt - w0, 1);
    chk("single_grant", TX_GRANT, 1);

    // Pointer now at 1: same three requesters go 2, 3, 0.
    send(0, 8'h20, 1); send(2, 8'h22, 1); send(3, 8'h23, 1);
    exp_wr.push_back({3'd2, 8'h22}); exp_wr.push_back({3'd3, 8'h23}); exp_wr.push_back({3'd0, 8'h20});
    drain();

    // Packet lock with a gap, config load and RX service inside the packet.
    w0 = wr_cnt;
    send(1, 8'hB1, 0); send(0, 8'hC0, 1);
    exp_wr.push_back({3'd1, 8'hB1});
    n = 0;
    while (wr_cnt == w0 && n < 50) begin cyc(1); n++; end
    cyc(1);
    CFG_BAUD = 13'd53; CFG_BIT8 = 1'b0; CFG_PAR_EN = 1'b1; CFG_ODD = 1'b1; CFG_LOAD = 1'b1;
    exp_baud = 13'd53;
    cyc(1);
    CFG_LOAD = 1'b0;
    uart_rx(8'h11, 0, 0, 0);
    cyc(12);
    chk("lock_stall", wr_cnt - w0, 1);
    chk("lock_grant", TX_GRANT, 1);
    chk("cfg_busy_locked", CFG_BUSY, 1);
    chk("cfg_baud_locked", UART_BAUD, BAUD_RST);
    send(1, 8'hB2, 0); send(1, 8'hB3, 1);
    exp_wr.push_back({3'd1, 8'hB2}); exp_wr.push_back({3'd1, 8'hB3}); exp_wr.push_back({3'd0, 8'hC0});
    drain();
    chk("cfg_busy_done", CFG_BUSY, 0);
    chk("cfg_baud_done", UART_BAUD, 13'd53);
    chk("cfg_bits_done", {UART_BIT8, UART_PAR_EN, UART_ODD}, 3'b011);

    // RX and TX requested in the same idle cycle: read first.
    uart_rx(8'h3C, 0, 1, 0);
    send(2, 8'h44, 1);
    exp_wr.push_back({3'd2, 8'h44});
    drain();
    chk("simul_rd_first", rd_cycle < wr_cycle, 1);
    chk("frm_cnt", ERR_FRM_CNT, m_frm);

    // Backpressure and parity counter saturation.
    rx_ready_want = 1'b0;
    r0 = oen_cnt;
    uart_rx(8'h55, 1, 0, 0);
    cyc(10);
    chk("par_cnt_first", ERR_PAR_CNT, m_par);
    force dut.err_par_cnt_reg = 16'hFFFF;
    cyc(1);
    release dut.err_par_cnt_reg;
    m_par = 16'hFFFF;
    uart_rx(8'h66, 1, 0, 1);
    cyc(20);
    chk("bp_no_read", oen_cnt - r0, 1);
    chk("bp_rx_valid", RX_VALID, 1);
    rx_ready_want = 1'b1;
    drain();
    chk("bp_reads", oen_cnt - r0, 2);
    chk("par_cnt_sat", ERR_PAR_CNT, m_par);
    chk("ovf_cnt", ERR_OVF_CNT, m_ovf);

    // Reset asserted during a write strobe.
    send(2, 8'h77, 1);
    n = 0;
    while (UART_WEN && n < 50) begin cyc(1); n++; end
    chk("rst_wr_seen", UART_WEN, 0);
    #2;
    RESET_N = 1'b0;
    exp_baud = BAUD_RST;
    #1;
    chk("rst_async_strobes", {UART_CSN, UART_WEN, UART_OEN}, 3'b111);
    chk("rst_async_ready", TX_READY, 0);
    exp_wr.delete();
    for (int i = 0; i < 4; i++) rq_head[i] = rq_tail[i];
    m_par = '0; m_frm = '0; m_ovf = '0;
    cyc(2);
    check_reset("rst_mid");
    RESET_N = 1'b1;
    cyc(2);
    send(0, 8'h99, 1);
    exp_wr.push_back({3'd0, 8'h99});
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/uart_bus_sched.md
# uart_bus_sched

Scheduler and arbiter in front of the CoreUART parallel host interface. Shares the single UART transmitter between NREQ byte-stream requesters using round-robin arbitration with packet lock. Drains received bytes into a valid/ready stream with per-byte error flags. Owns the CSN/WEN/OEN strobes and the registered UART configuration (baud, bit8, parity); both are updated only at safe points.

## Interface
Parameters:
- NREQ, 4, number of TX requesters (2..8)
- HOLDOFF, 2, idle cycles after every UART strobe before TXRDY/RXRDY are re-sampled (1..7)
- BAUD_RST, 13'd26, BAUD_VAL after reset

Ports:
- CLK  in  1  system clock; all logic on the rising edge
- RESET_N  in  1  asynchronous, active-low reset
- TX_DATA  in  NREQ*8  byte of requester i at [8i+7:8i]
- TX_VALID  in  NREQ  requester i has a byte
- TX_LAST  in  NREQ  byte of requester i ends its packet
- TX_READY  out  NREQ  byte of requester i accepted this cycle
- TX_GRANT  out  3  id of the current/last granted requester
- RX_DATA  out  8  received byte
- RX_PERR, RX_FERR, RX_OVF  out  1 each  error flags captured with RX_DATA
- RX_VALID  out  1  RX holding register full
- RX_READY  in  1  consumer accepts the RX byte
- CFG_BAUD  in  13, CFG_BIT8, CFG_PAR_EN, CFG_ODD  in  1 each  new configuration
- CFG_LOAD  in  1  single-cycle pulse; request to apply CFG_*
- CFG_BUSY  out  1  load pending, not yet applied
- ERR_PAR_CNT, ERR_FRM_CNT, ERR_OVF_CNT  out  16 each  saturating error counters
- UART_CSN, UART_WEN, UART_OEN  out  1 each  active-low strobes to the UART
- UART_DIN  out  8  UART DATA_IN
- UART_BAUD  out  13, UART_BIT8, UART_PAR_EN, UART_ODD  out  1 each  UART configuration
- UART_DOUT  in  8, UART_TXRDY, UART_RXRDY, UART_PERR, UART_FERR, UART_OVF  in  1 each  UART status

## Operation
- Bus FSM states: IDLE, WR, RD, HOLD.
- IDLE: if UART_RXRDY=1 and RX_VALID=0, go to RD. RX always has priority over TX in the same cycle. Otherwise, if UART_TXRDY=1 and the granted requester has TX_VALID=1, go to WR. Otherwise stay.
- WR (1 cycle): UART_CSN=0, UART_WEN=0, UART_DIN = granted byte, TX_READY[grant]=1. Then go to HOLD.
- RD (1 cycle): UART_CSN=0, UART_OEN=0. At the end of the cycle, capture UART_DOUT, PERR, FERR and OVF into the holding register; RX_VALID=1 from the next cycle. Then go to HOLD.
- HOLD: stay for HOLDOFF cycles, strobes high, then go to IDLE.
- Arbiter, when unlocked: pick the first valid requester after TX_GRANT in round-robin order, checked in IDLE. The choice is made and the WR entered in the same IDLE cycle.
- Lock: set when a byte with TX_LAST=0 is accepted. Cleared when a byte with TX_LAST=1 is accepted.
- While locked, the grant does not move. If the granted requester has TX_VALID=0, no TX occurs; RX service continues.
- RX handshake: RX_VALID clears on RX_VALID & RX_READY. While RX_VALID=1, the UART is not read, and UART overflow is then reported by the UART.
- Error counters increment in the RD cycle for each set flag. They saturate at 16'hFFFF.
- CFG_LOAD: latch CFG_* into a shadow and set CFG_BUSY. The shadow is applied to UART_* in the first IDLE cycle with lock clear. CFG_BUSY clears in that same cycle, and no WR or RD starts in that cycle. A new CFG_LOAD while busy overwrites the shadow.

## Timing
- Reset values: UART_CSN/WEN/OEN=1, UART_DIN=0, UART_BAUD=BAUD_RST, UART_BIT8=1, UART_PAR_EN=0, UART_ODD=0, TX_READY=0, TX_GRANT=NREQ-1 (so requester 0 wins first), lock=0, RX_VALID=0, RX_DATA and flags=0, counters=0, CFG_BUSY=0, FSM=IDLE.
- All outputs are registered except TX_READY, which is decoded from state=WR and the grant register.
- TX_VALID to strobe: WR is entered on the edge after IDLE samples TX_VALID=1, so the strobe is visible 1 cycle after TX_VALID if idle.
- Minimum spacing between strobes is 1+HOLDOFF cycles.
- RD strobe to RX_VALID: 1 cycle.
- Reset asserted mid-WR/RD: strobes go high immediately (async). The UART byte outcome is not defined; requesters must retransmit.

## Test plan
- Single byte: req1 sends 8'hA5, LAST=1 -> exactly one WEN pulse with UART_DIN=A5; TX_READY[1] high for that cycle only; next strobe is no earlier than HOLDOFF+1 cycles later.
- Round robin: req0, req2, req3 each hold one LAST byte -> grant order 0,2,3. Repeat with 2,3,0 after rotating the pointer.
- Packet lock: req1 sends 3 bytes (LAST on the 3rd) while req0 is valid -> req1's three bytes are contiguous; req0 follows. A gap in req1 TX_VALID stalls TX without switching grant.
- Simultaneous events: UART_RXRDY and TX valid in the same IDLE cycle -> RD first (OEN pulse), capture 8'h3C with FERR=1, ERR_FRM_CNT=1; WR follows after HOLD.
- Backpressure: RX_READY=0 with RX_VALID=1 and RXRDY=1 -> no OEN until RX_READY pulses. Force ERR_PAR_CNT to FFFF -> stays FFFF on the next parity error.
- Config: CFG_LOAD with baud 13'd53 mid-packet -> CFG_BUSY stays high until the LAST byte is accepted; UART_BAUD changes in the next IDLE cycle with no strobe in that cycle. Reset mid-WR returns all reset values.
